// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, flag/control
// bit positions and reset values.
package mmio_pkg;

    localparam logic [2:0] OFS_PORT_OUT = 3'd0;
    localparam logic [2:0] OFS_PORT_IN  = 3'd1;
    localparam logic [2:0] OFS_STATUS   = 3'd2;
    localparam logic [2:0] OFS_TMR_CMP  = 3'd3;
    localparam logic [2:0] OFS_CTRL     = 3'd4;
    localparam logic [2:0] OFS_TMR_CNT  = 3'd5;

    localparam int ST_IN_CHANGED   = 0;
    localparam int ST_TMR_MATCH    = 1;

    localparam int CTRL_TMR_EN     = 0;
    localparam int CTRL_IRQ_EN_IN  = 1;
    localparam int CTRL_IRQ_EN_TMR = 2;

    localparam logic [31:0] RST_PORT_OUT = 32'h0;
    localparam logic [1:0]  RST_STATUS   = 2'b00;
    localparam logic [2:0]  RST_CTRL     = 3'b000;

endpackage

// File: rtl/mmio_port_responder_sync.sv
// Two-flop synchronizer for PortIn plus a one-cycle history register,
// flagging a change whenever the synchronized value differs from the previous one.
module input_sync_change #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_q,
    output logic         changed
);

    logic [W-1:0] meta_q;
    logic [W-1:0] stage_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= '0;
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            meta_q  <= async_i;
            stage_q <= meta_q;
            prev_q  <= stage_q;
        end
    end

    assign sync_q  = stage_q;
    assign changed = (stage_q != prev_q);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder on the single-cycle data bus: combinational loads, clocked stores,
// PortOut/PortIn registers, sticky W1C status flags and a compare timer.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000,
    parameter int          PORT_IN_W = 8,
    parameter int          TIMER_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [31:0]          Address,
    input  logic [31:0]          WriteData,
    output logic [31:0]          ReadData,
    output logic                 Hit,
    input  logic [PORT_IN_W-1:0] PortIn,
    output logic [31:0]          PortOut,
    output logic                 Irq
);

    localparam logic [TIMER_W-1:0] CNT_ONE = TIMER_W'(1);

    logic [2:0]           ofs;
    logic                 wr_en;
    logic                 rd_en;

    logic [PORT_IN_W-1:0] sync_in;
    logic                 in_changed;

    logic [31:0]          port_out_q, port_out_d;
    logic [1:0]           status_q,   status_d;
    logic [TIMER_W-1:0]   cmp_q,      cmp_d;
    logic [2:0]           ctrl_q,     ctrl_d;
    logic [TIMER_W-1:0]   cnt_q,      cnt_d;
    logic                 tmr_hit;
    logic [1:0]           clr_mask;

    input_sync_change #(.W(PORT_IN_W)) u_in_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (PortIn),
        .sync_q  (sync_in),
        .changed (in_changed)
    );

    assign Hit   = (Address[31:5] == IO_BASE[31:5]);
    assign ofs   = Address[4:2];
    assign wr_en = Hit & MemWrite;
    assign rd_en = Hit & MemRead;

    always_comb begin
        port_out_d = port_out_q;
        cmp_d      = cmp_q;
        ctrl_d     = ctrl_q;
        clr_mask   = 2'b00;

        tmr_hit = ctrl_q[CTRL_TMR_EN] && (cnt_q == cmp_q);
        if (tmr_hit) begin
            cnt_d = '0;
        end else if (ctrl_q[CTRL_TMR_EN]) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // A TMR_CNT store lands after the timer update so it overrides increment/wrap.
        if (wr_en) begin
            case (ofs)
                OFS_PORT_OUT: port_out_d = WriteData;
                OFS_STATUS:   clr_mask   = WriteData[1:0];
                OFS_TMR_CMP:  cmp_d      = WriteData[TIMER_W-1:0];
                OFS_CTRL:     ctrl_d     = WriteData[2:0];
                OFS_TMR_CNT:  cnt_d      = WriteData[TIMER_W-1:0];
                default:      ;
            endcase
        end

        if (rd_en && (ofs == OFS_PORT_IN)) begin
            clr_mask[ST_IN_CHANGED] = 1'b1;
        end

        // New events win over clears landing in the same cycle.
        status_d[ST_IN_CHANGED] = in_changed | (status_q[ST_IN_CHANGED] & ~clr_mask[ST_IN_CHANGED]);
        status_d[ST_TMR_MATCH]  = tmr_hit    | (status_q[ST_TMR_MATCH]  & ~clr_mask[ST_TMR_MATCH]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q <= RST_PORT_OUT;
            status_q   <= RST_STATUS;
            cmp_q      <= '1;
            ctrl_q     <= RST_CTRL;
            cnt_q      <= '0;
        end else begin
            port_out_q <= port_out_d;
            status_q   <= status_d;
            cmp_q      <= cmp_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (rd_en) begin
            case (ofs)
                OFS_PORT_OUT: ReadData = port_out_q;
                OFS_PORT_IN:  ReadData = 32'(sync_in);
                OFS_STATUS:   ReadData = {30'h0, status_q};
                OFS_TMR_CMP:  ReadData = 32'(cmp_q);
                OFS_CTRL:     ReadData = {29'h0, ctrl_q};
                OFS_TMR_CNT:  ReadData = 32'(cnt_q);
                default:      ReadData = 32'h0;
            endcase
        end
    end

    assign PortOut = port_out_q;
    assign Irq     = |(status_q & ctrl_q[CTRL_IRQ_EN_TMR:CTRL_IRQ_EN_IN]);

endmodule
